// File: rtl/gray_scale_pkg.sv
// Shared types and coefficient tables for the RGB->gray pipeline.
// Table values are given for 8-bit coefficients and rescaled to the instance width.
package gray_scale_pkg;

  localparam int unsigned CoefMaxW = 16;

  typedef enum logic [1:0] {
    GRAY_BT601,
    GRAY_BT709,
    GRAY_AVG,
    GRAY_CUSTOM
  } gray_mode_e;

  typedef struct packed {
    logic [CoefMaxW-1:0] cr;
    logic [CoefMaxW-1:0] cg;
    logic [CoefMaxW-1:0] cb;
  } gray_coef_t;

  localparam gray_coef_t CoefBt601 = '{cr: 16'd77, cg: 16'd150, cb: 16'd29};
  localparam gray_coef_t CoefBt709 = '{cr: 16'd54, cg: 16'd183, cb: 16'd19};
  localparam gray_coef_t CoefAvg   = '{cr: 16'd85, cg: 16'd86,  cb: 16'd85};
  // Unity gain on green: one bit wider than the coefficient field itself.
  localparam gray_coef_t CoefGreen = '{cr: 16'd0,  cg: 16'd256, cb: 16'd0};

  function automatic logic [CoefMaxW-1:0] scale_coef(logic [CoefMaxW-1:0] c, int unsigned w);
    if (w >= 8) return c << (w - 8);
    return c >> (8 - w);
  endfunction

  function automatic gray_coef_t gray_coef_lookup(gray_mode_e mode, int unsigned w);
    gray_coef_t c;
    unique case (mode)
      GRAY_BT601:  c = CoefBt601;
      GRAY_BT709:  c = CoefBt709;
      GRAY_AVG:    c = CoefAvg;
      GRAY_CUSTOM: c = CoefGreen;
    endcase
    c.cr = scale_coef(c.cr, w);
    c.cg = scale_coef(c.cg, w);
    c.cb = scale_coef(c.cb, w);
    return c;
  endfunction

endpackage

// File: rtl/gray_coef_mac.sv
// Single-channel pixel x coefficient multiply used by stage 1 of gray_scale_pipe.
// The coefficient is one bit wider than COEF_WIDTH so unity gain (2**COEF_WIDTH) fits.
module gray_coef_mac #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COEF_WIDTH  = 8
) (
  input  logic [PIXEL_WIDTH-1:0]            px_i,
  input  logic [COEF_WIDTH:0]               coef_i,
  output logic [PIXEL_WIDTH+COEF_WIDTH-1:0] prod_o
);
  localparam int unsigned ProdW = PIXEL_WIDTH + COEF_WIDTH;

  always_comb prod_o = ProdW'(px_i) * ProdW'(coef_i);

endmodule

// File: rtl/gray_scale_pipe.sv
// Two-stage RGB->gray converter with rounding, saturation and valid/ready backpressure.
// Optional feature macro GRAY_CUSTOM_COEF_EN adds writable coefficients for mode 3.
module gray_scale_pipe
  import gray_scale_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COEF_WIDTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [3*PIXEL_WIDTH-1:0] in_px_rgb_i,
  input  logic [1:0]               mode_i,
`ifdef GRAY_CUSTOM_COEF_EN
  input  logic                     cfg_we_i,
  input  logic [3*COEF_WIDTH-1:0]  cfg_coef_i,
`endif
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PIXEL_WIDTH-1:0]   out_px_gray_o
);
  localparam int unsigned ProdW = PIXEL_WIDTH + COEF_WIDTH;
  localparam int unsigned SumW  = ProdW + 2;
  localparam int unsigned YW    = SumW - COEF_WIDTH;
  localparam logic [SumW-1:0] Half = SumW'(1) << (COEF_WIDTH - 1);

  logic                   adv, accept;
  gray_coef_t             tab;
  logic [COEF_WIDTH:0]    coef_r, coef_g, coef_b;
  logic [ProdW-1:0]       prod_r, prod_g, prod_b;
  logic [ProdW-1:0]       pr_d, pr_q, pg_d, pg_q, pb_d, pb_q;
  logic                   s1_valid_d, s1_valid_q;
  logic                   out_valid_d, out_valid_q;
  logic [PIXEL_WIDTH-1:0] out_px_d, out_px_q;
  logic [SumW-1:0]        sum;
  logic [YW-1:0]          y;
  logic [PIXEL_WIDTH-1:0] sat;

  // A held output stalls the whole pipe; a drained or empty output lets both stages move.
  assign adv         = !out_valid_q || out_ready_i;
  assign in_ready_o  = adv && !reset_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign out_px_gray_o = out_px_q;

`ifdef GRAY_CUSTOM_COEF_EN
  logic [3*COEF_WIDTH-1:0] cust_d, cust_q;

  assign cust_d = cfg_we_i ? cfg_coef_i : cust_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) cust_q <= '0;
    else         cust_q <= cust_d;
  end
`endif

  always_comb begin
    tab    = gray_coef_lookup(gray_mode_e'(mode_i), COEF_WIDTH);
    coef_r = (COEF_WIDTH+1)'(tab.cr);
    coef_g = (COEF_WIDTH+1)'(tab.cg);
    coef_b = (COEF_WIDTH+1)'(tab.cb);
`ifdef GRAY_CUSTOM_COEF_EN
    // Registered value, so a write on the accept edge only affects later pixels.
    if (gray_mode_e'(mode_i) == GRAY_CUSTOM) begin
      coef_r = {1'b0, cust_q[3*COEF_WIDTH-1 -: COEF_WIDTH]};
      coef_g = {1'b0, cust_q[2*COEF_WIDTH-1 -: COEF_WIDTH]};
      coef_b = {1'b0, cust_q[COEF_WIDTH-1:0]};
    end
`endif
  end

  gray_coef_mac #(.PIXEL_WIDTH(PIXEL_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_mac_r (
    .px_i   (in_px_rgb_i[3*PIXEL_WIDTH-1 -: PIXEL_WIDTH]),
    .coef_i (coef_r),
    .prod_o (prod_r)
  );

  gray_coef_mac #(.PIXEL_WIDTH(PIXEL_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_mac_g (
    .px_i   (in_px_rgb_i[2*PIXEL_WIDTH-1 -: PIXEL_WIDTH]),
    .coef_i (coef_g),
    .prod_o (prod_g)
  );

  gray_coef_mac #(.PIXEL_WIDTH(PIXEL_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_mac_b (
    .px_i   (in_px_rgb_i[PIXEL_WIDTH-1:0]),
    .coef_i (coef_b),
    .prod_o (prod_b)
  );

  always_comb begin
    sum = SumW'(pr_q) + SumW'(pg_q) + SumW'(pb_q) + Half;
    y   = YW'(sum >> COEF_WIDTH);
    sat = (y > YW'({PIXEL_WIDTH{1'b1}})) ? {PIXEL_WIDTH{1'b1}} : y[PIXEL_WIDTH-1:0];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    pr_d        = pr_q;
    pg_d        = pg_q;
    pb_d        = pb_q;
    out_valid_d = out_valid_q;
    out_px_d    = out_px_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        pr_d = prod_r;
        pg_d = prod_g;
        pb_d = prod_b;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_px_d = sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      pr_q        <= '0;
      pg_q        <= '0;
      pb_q        <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      pr_q        <= pr_d;
      pg_q        <= pg_d;
      pb_q        <= pb_d;
      out_valid_q <= out_valid_d;
      out_px_q    <= out_px_d;
    end
  end

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Scoreboard bench for gray_scale_pipe: expected gray values are queued on accept and
// compared in order as the DUT drains them; also checks hold-stability under stall.
module tb_gray_scale_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_rgb = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_gray;
`ifdef GRAY_CUSTOM_COEF_EN
  logic        cfg_we = 1'b0;
  logic [23:0] cfg_coef = '0;
  int          cust_r = 0, cust_g = 0, cust_b = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int sb_q[$];
  int out_cyc_q[$];
  logic       held = 1'b0;
  logic [7:0] held_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_scale_pipe #(.PIXEL_WIDTH(8), .COEF_WIDTH(8)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_px_rgb_i   (in_rgb),
    .mode_i        (mode),
`ifdef GRAY_CUSTOM_COEF_EN
    .cfg_we_i      (cfg_we),
    .cfg_coef_i    (cfg_coef),
`endif
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_px_gray_o (out_gray)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int model(input logic [7:0] r, g, b, input logic [1:0] m);
    int cr, cg, cb, s;
    case (m)
      2'd0:    begin cr = 77; cg = 150; cb = 29; end
      2'd1:    begin cr = 54; cg = 183; cb = 19; end
      2'd2:    begin cr = 85; cg = 86;  cb = 85; end
`ifdef GRAY_CUSTOM_COEF_EN
      default: begin cr = cust_r; cg = cust_g; cb = cust_b; end
`else
      default: begin cr = 0; cg = 256; cb = 0; end
`endif
    endcase
    s = (int'(r) * cr + int'(g) * cg + int'(b) * cb + 128) >> 8;
    return (s > 255) ? 255 : s;
  endfunction

  // Inputs change only at posedge+1; in_ready is sampled at the negedge.
  task automatic send_px(input logic [7:0] r, g, b, input logic [1:0] m, input int exp);
    int n = 0;
    logic done = 1'b0;
    in_valid = 1'b1;
    in_rgb   = {r, g, b};
    mode     = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        done = 1'b1;
      end else if (++n > 200) begin
        check_val("in_ready_timeout", 0, 1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_val("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

`ifdef GRAY_CUSTOM_COEF_EN
  task automatic cfg_write(input int r, g, b);
    cfg_we   = 1'b1;
    cfg_coef = {8'(r), 8'(g), 8'(b)};
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    cust_r = r; cust_g = g; cust_b = b;
  endtask
`endif

  always @(negedge clk) begin
    int e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_val("hold_valid", int'(out_valid), 1);
        check_val("hold_data", int'(out_gray), int'(held_val));
      end
      if (out_valid && !out_ready) begin
        check_val("stall_in_ready", int'(in_ready), 0);
        held     = 1'b1;
        held_val = out_gray;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = (sb_q.size() != 0) ? sb_q.pop_front() : -1;
        check_val("gray_out", int'(out_gray), e);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rr, gg, bb;
    logic [1:0] mm;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_out_valid", int'(out_valid), 0);
    check_val("reset_out_gray", int'(out_gray), 0);
    check_val("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed values and exact two-cycle latency.
    send_px(8'd255, 8'd0, 8'd0, 2'd0, 77);
    @(negedge clk);
    check_val("latency_c1_valid", int'(out_valid), 0);
    @(negedge clk);
    check_val("latency_c2_valid", int'(out_valid), 1);
    wait_drain();
    send_px(8'd255, 8'd255, 8'd255, 2'd0, 255);
    send_px(8'd0, 8'd0, 8'd0, 2'd0, 0);
    send_px(8'd0, 8'd255, 8'd0, 2'd1, 182);
    send_px(8'd90, 8'd90, 8'd90, 2'd2, 90);
`ifndef GRAY_CUSTOM_COEF_EN
    send_px(8'd17, 8'd123, 8'd200, 2'd3, 123);
`endif
    wait_drain();

    // Back-to-back stream with per-pixel mode toggle.
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      rr = 8'($urandom_range(0, 255));
      gg = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      send_px(rr, gg, bb, 2'(i % 2), model(rr, gg, bb, 2'(i % 2)));
    end
    wait_drain();
    check_val("stream_count", out_cyc_q.size(), 8);
    if (out_cyc_q.size() == 8) check_val("stream_span", out_cyc_q[7] - out_cyc_q[0], 7);

    // Five-cycle downstream stall in the middle of a stream.
    fork
      for (int i = 0; i < 10; i++) begin
        rr = 8'($urandom_range(0, 255));
        gg = 8'($urandom_range(0, 255));
        bb = 8'($urandom_range(0, 255));
        send_px(rr, gg, bb, 2'(i % 3), model(rr, gg, bb, 2'(i % 3)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random modes with random backpressure.
    fork
      for (int i = 0; i < 24; i++) begin
        rr = 8'($urandom_range(0, 255));
        gg = 8'($urandom_range(0, 255));
        bb = 8'($urandom_range(0, 255));
        mm = 2'($urandom_range(0, 3));
        send_px(rr, gg, bb, mm, model(rr, gg, bb, mm));
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with two pixels in flight: both must vanish.
    out_ready = 1'b0;
    send_px(8'd10, 8'd20, 8'd30, 2'd0, model(8'd10, 8'd20, 8'd30, 2'd0));
    send_px(8'd40, 8'd50, 8'd60, 2'd1, model(8'd40, 8'd50, 8'd60, 2'd1));
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_out_valid", int'(out_valid), 0);
    check_val("post_reset_out_gray", int'(out_gray), 0);
    check_val("post_reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    out_cyc_q.delete();
    repeat (6) @(posedge clk);
    check_val("flushed_outputs", out_cyc_q.size(), 0);
    #1;

`ifdef GRAY_CUSTOM_COEF_EN
    cfg_write(255, 255, 255);
    send_px(8'd255, 8'd255, 8'd255, 2'd3, 255);
    wait_drain();
    cfg_write(0, 0, 128);
    send_px(8'd0, 8'd0, 8'd200, 2'd3, 100);
    wait_drain();
    // Write on the accept edge: this pixel keeps the previous coefficients.
    cfg_we   = 1'b1;
    cfg_coef = {8'd128, 8'd0, 8'd0};
    send_px(8'd0, 8'd0, 8'd200, 2'd3, 100);
    cfg_we = 1'b0;
    cust_r = 128; cust_g = 0; cust_b = 0;
    send_px(8'd200, 8'd0, 8'd0, 2'd3, 100);
    send_px(8'd0, 8'd0, 8'd200, 2'd3, 0);
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
